// File: rtl/matrix_fill_engine_pkg.sv
// matrix_fill_engine_pkg: shared encodings and LFSR constants for the matrix fill engine
package matrix_fill_engine_pkg;
  typedef enum logic [1:0] {MODE_RAND, MODE_CONST, MODE_IDENT, MODE_RAMP} mode_e;
  typedef enum logic [1:0] {IDLE, DIM, GEN, DONE} state_e;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/matrix_fill_engine_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with seed load (zero seed replaced) and advance enable
module lfsr16
  import matrix_fill_engine_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= LFSR_SEED;
    else if (load) q <= (seed == '0) ? LFSR_SEED : seed;
    else if (en) q <= lfsr_step(q);
endmodule

// File: rtl/matrix_fill_engine.sv
// matrix_fill_engine: fills an m x n matrix slot row-major with random, constant, identity or ramp data
module matrix_fill_engine
  import matrix_fill_engine_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DIM_W   = 3,
  parameter int SLOT_W  = 2,
  parameter int VAL_W   = 4,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DIM_W-1:0]  target_m,
  input  logic [DIM_W-1:0]  target_n,
  input  logic [SLOT_W-1:0] target_slot,
  input  logic [VAL_W-1:0]  max_val,
  input  logic [DATA_W-1:0] const_val,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              dim_we,
  output logic [DIM_W-1:0]  dim_m,
  output logic [DIM_W-1:0]  dim_n,
  output logic              wr_valid,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [DIM_W-1:0]  wr_row,
  output logic [DIM_W-1:0]  wr_col,
  output logic [DATA_W-1:0] wr_data
);
  localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);
  state_e             state;
  mode_e              mode_q;
  logic [DIM_W-1:0]   m_q, n_q, i, j, ni, nj;
  logic [SLOT_W-1:0]  slot_q;
  logic [VAL_W-1:0]   max_q, sample;
  logic [DATA_W-1:0]  const_q, pdata;
  logic [15:0]        lfsr;
  logic               acc, adv, lastc, last, pvalid, bad_req;
  lfsr16 u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == IDLE && seed_load),
    .seed (seed),
    .en   (adv),
    .q    (lfsr)
  );
  // The next element is computed one edge ahead so every wr_* output is a register;
  // in random mode the sample comes from the LFSR value it will hold after this edge.
  always_comb begin
    bad_req = target_m == '0 || target_n == '0 || target_m > MAX_D || target_n > MAX_D;
    acc     = wr_valid && wr_ready;
    lastc   = j == n_q - 1'b1;
    last    = lastc && i == m_q - 1'b1;
    adv     = state == GEN && mode_q == MODE_RAND && !abort && (acc || !wr_valid);
    ni      = (acc && lastc) ? i + 1'b1 : i;
    nj      = acc ? (lastc ? '0 : j + 1'b1) : j;
    sample  = VAL_W'(adv ? lfsr_step(lfsr) : lfsr);
    pvalid  = mode_q != MODE_RAND || sample <= max_q;
    pdata   = mode_q == MODE_RAND  ? DATA_W'(sample) :
              mode_q == MODE_CONST ? const_q :
              mode_q == MODE_IDENT ? DATA_W'(ni == nj) :
                                     DATA_W'(ni) * DATA_W'(n_q) + DATA_W'(nj);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= MODE_RAND;
      m_q      <= '0;
      n_q      <= '0;
      slot_q   <= '0;
      max_q    <= '0;
      const_q  <= '0;
      i        <= '0;
      j        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      dim_we   <= 1'b0;
      dim_m    <= '0;
      dim_n    <= '0;
      wr_valid <= 1'b0;
      wr_slot  <= '0;
      wr_row   <= '0;
      wr_col   <= '0;
      wr_data  <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      dim_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q  <= mode_e'(mode);
          m_q     <= target_m;
          n_q     <= target_n;
          slot_q  <= target_slot;
          max_q   <= max_val;
          const_q <= const_val;
          if (bad_req) err <= 1'b1;
          else begin
            state   <= DIM;
            busy    <= 1'b1;
            dim_we  <= 1'b1;
            dim_m   <= target_m;
            dim_n   <= target_n;
            wr_slot <= target_slot;
            i       <= '0;
            j       <= '0;
          end
        end
        DIM: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          state    <= GEN;
          wr_slot  <= slot_q;
          wr_valid <= pvalid;
          wr_row   <= ni;
          wr_col   <= nj;
          wr_data  <= pdata;
        end
        GEN: if (abort) begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_valid <= 1'b0;
          i        <= '0;
          j        <= '0;
        end else if (acc && last) begin
          state    <= DONE;
          done     <= 1'b1;
          wr_valid <= 1'b0;
          i        <= '0;
          j        <= '0;
        end else if (acc || !wr_valid) begin
          i        <= ni;
          j        <= nj;
          wr_valid <= pvalid;
          wr_row   <= ni;
          wr_col   <= nj;
          wr_data  <= pdata;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_fill_engine.sv
// tb_matrix_fill_engine: directed self-checking bench for matrix_fill_engine
module tb_matrix_fill_engine;
  logic        clk = 0, rst_n = 0, start = 0, abort = 0, seed_load = 0, wr_ready = 0;
  logic [1:0]  mode = 0, target_slot = 0;
  logic [2:0]  target_m = 0, target_n = 0;
  logic [3:0]  max_val = 0;
  logic [15:0] const_val = 0, seed = 0;
  logic        busy, done, err, dim_we, wr_valid;
  logic [2:0]  dim_m, dim_n, wr_row, wr_col;
  logic [1:0]  wr_slot;
  logic [15:0] wr_data;
  logic [15:0] ref_l;
  int total = 0, bad = 0;

  matrix_fill_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .target_m(target_m), .target_n(target_n), .target_slot(target_slot),
    .max_val(max_val), .const_val(const_val), .seed_load(seed_load), .seed(seed),
    .wr_ready(wr_ready), .busy(busy), .done(done), .err(err), .dim_we(dim_we),
    .dim_m(dim_m), .dim_n(dim_n), .wr_valid(wr_valid), .wr_slot(wr_slot),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [1:0] md, input int m, input int n, input logic [15:0] cv,
                      input logic [3:0] mx, input logic [1:0] sl, input bit ld, input logic [15:0] sd,
                      input int sr, input int sc, input int sn, input bit bs);
    int nw = 0, stall = sn, er, ec;
    bit got = 0, have = 0;
    logic [15:0] e = 0;
    mode = md; target_m = 3'(m); target_n = 3'(n); const_val = cv; max_val = mx;
    target_slot = sl; seed_load = ld; seed = sd; wr_ready = 1; start = 1;
    if (ld) ref_l = (sd == 0) ? 16'hACE1 : sd;
    tick;
    start = 0; seed_load = 0;
    chk("dim_we", dim_we, 1);
    chk("dim_mn", {dim_m, dim_n}, {3'(m), 3'(n)});
    chk("busy_dim", busy, 1);
    chk("slot", wr_slot, sl);
    chk("dim_nowr", wr_valid, 0);
    if (bs) begin start = 1; target_m = 0; end
    for (int c = 0; c < 400 && !got; c++) begin
      tick;
      start = 0;
      if (bs && c == 0) chk("busy_start_err", err, 0);
      if (done) got = 1;
      else begin
        if (md != 0) chk("valid_gen", wr_valid, 1);
        wr_ready = 1;
        if (wr_valid) begin
          er = nw / n; ec = nw % n;
          if (!have) begin
            if (md == 0) begin
              while (ref_l[3:0] > mx) ref_l = nxt(ref_l);
              e = {12'd0, ref_l[3:0]};
            end else if (md == 1) e = cv;
            else if (md == 2) e = (er == ec) ? 16'd1 : 16'd0;
            else e = 16'(er * n + ec);
            have = 1;
          end
          chk("row", wr_row, er);
          chk("col", wr_col, ec);
          chk("data", wr_data, e);
          if (er == sr && ec == sc && stall > 0) begin
            wr_ready = 0;
            stall--;
            chk("lfsr_hold", dut.u_lfsr.q, ref_l);
          end
          if (wr_ready) begin
            if (md == 0) begin
              chk("rand_le_max", wr_data <= {12'd0, mx}, 1);
              ref_l = nxt(ref_l);
            end
            nw++;
            have = 0;
          end
        end
      end
    end
    chk("done_seen", got, 1);
    chk("nwrites", nw, m * n);
    tick;
    chk("done_pulse", done, 0);
    chk("busy_end", busy, 0);
  endtask

  task automatic bad_req(input int m, input int n);
    mode = 1; target_m = 3'(m); target_n = 3'(n); start = 1;
    tick;
    start = 0;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    chk("err_dim_we", dim_we, 0);
    chk("err_wr", wr_valid, 0);
    tick;
    chk("err_clear", err, 0);
    chk("err_busy2", busy, 0);
    chk("err_dim_we2", dim_we, 0);
  endtask

  initial begin
    bit saw;
    ref_l = 16'hACE1;
    #12 rst_n = 1;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dim_we", dim_we, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
    fill(2'd1, 2, 3, 16'd7, 4'd0, 2'd2, 0, 0, -1, -1, 0, 0);
    fill(2'd2, 3, 4, 16'd0, 4'd0, 2'd1, 0, 0, -1, -1, 0, 0);
    fill(2'd0, 3, 3, 16'd0, 4'd5, 2'd3, 1, 16'd0, -1, -1, 0, 0);
    fill(2'd3, 2, 2, 16'd0, 4'd0, 2'd0, 0, 0, 0, 1, 3, 0);
    fill(2'd0, 2, 4, 16'd0, 4'd9, 2'd1, 1, 16'h1234, -1, -1, 0, 0);
    bad_req(0, 3);
    bad_req(2, 6);
    fill(2'd1, 1, 1, 16'h55AA, 4'd0, 2'd3, 0, 0, -1, -1, 0, 1);
    mode = 3; target_m = 3; target_n = 3; wr_ready = 1; start = 1;
    tick; start = 0;
    tick; tick; tick;
    chk("abort_pre_col", wr_col, 2);
    abort = 1; wr_ready = 0;
    tick;
    abort = 0;
    chk("abort_wr_valid", wr_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_dim_we", dim_we, 0);
    saw = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      saw |= done | err;
    end
    chk("abort_no_done", saw, 0);
    mode = 1; target_m = 5; target_n = 5; const_val = 16'hBEEF; wr_ready = 1; start = 1;
    tick; start = 0;
    tick; tick;
    chk("pre_rst_valid", wr_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_valid", wr_valid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_data", wr_data, 0);
    chk("rst_async_dim", {dim_m, dim_n}, 0);
    #1 rst_n = 1;
    ref_l = 16'hACE1;
    saw = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      saw |= done | busy | wr_valid;
    end
    chk("post_rst_idle", saw, 0);
    chk("post_rst_lfsr", dut.u_lfsr.q, ref_l);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
